// File: rtl/tx_frame_packer.sv
// tx_frame_packer: frames a payload snapshot as HEADER, payload bytes, checksum
// and feeds it one byte at a time to a UART transmitter, with an idle gap
// after every byte.
//
// Handshake with the UART: txen is a one-cycle load strobe with txdb valid in
// the same cycle (txdb reads 8'h00 otherwise). The UART answers by raising
// tx_busy some cycles later and dropping it when the byte has been shifted
// out. There is no backpressure on txen: the packer only issues the next byte
// after tx_busy has been seen low and the gap has elapsed.
module tx_frame_packer #(
  parameter int         NBYTES     = 4,
  parameter logic [7:0] HEADER     = 8'hAA,
  parameter int         CSUM_MODE  = 0,
  parameter int         GAP_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [8*NBYTES-1:0]   data_in,
  input  logic                  tx_busy,
  output logic                  txen,
  output logic [7:0]            txdb,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  start_drop,
  output logic [2:0]            state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_ARM     = 3'd2,
    S_WAIT_TX = 3'd3,
    S_GAP     = 3'd4
  } state_t;

  // Index of the checksum byte, i.e. the last byte of a frame.
  localparam logic [4:0]  LAST_IDX = 5'(NBYTES + 1);
  // Final gap count value before the gap ends (unused when GAP_CYCLES is 0).
  localparam logic [15:0] GAP_LAST = (GAP_CYCLES == 0) ? 16'd0 : 16'(GAP_CYCLES - 1);

  state_t                state_q, state_d;
  logic [4:0]            idx_q, idx_d;
  logic [15:0]           gap_q, gap_d;
  logic                  arm_q, arm_d;
  logic [8*NBYTES-1:0]   snap_q, snap_d;
  logic                  txen_q, txen_d;
  logic [7:0]            txdb_q, txdb_d;

  logic [7:0]            csum;
  logic [7:0]            frame_byte;
  logic                  byte_end;
  logic                  done_c;

  // Checksum over the payload snapshot only: XOR or 8-bit wrapping sum.
  always_comb begin
    csum = 8'h00;
    for (int i = 0; i < NBYTES; i++) begin
      if (CSUM_MODE == 1) csum = csum + snap_q[8*(NBYTES-1-i) +: 8];
      else                csum = csum ^ snap_q[8*(NBYTES-1-i) +: 8];
    end
  end

  // Select frame byte at the current index: header, payload bytes, checksum.
  always_comb begin
    frame_byte = HEADER;
    for (int i = 0; i < NBYTES; i++) begin
      if (idx_q == 5'(i + 1)) frame_byte = snap_q[8*(NBYTES-1-i) +: 8];
    end
    if (idx_q == LAST_IDX) frame_byte = csum;
  end

  // Next-state logic. txen/txdb are registered from ISSUE, so the UART strobe
  // lands in the cycle after ISSUE, two cycles after start is sampled. With no
  // gap configured, WAIT_TX finishes the byte itself instead of visiting GAP.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    gap_d    = gap_q;
    arm_d    = arm_q;
    snap_d   = snap_q;
    txen_d   = 1'b0;
    txdb_d   = 8'h00;
    byte_end = 1'b0;
    done_c   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          snap_d  = data_in;
          idx_d   = 5'd0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        txen_d  = 1'b1;
        txdb_d  = frame_byte;
        arm_d   = 1'b0;
        state_d = S_ARM;
      end
      S_ARM: begin
        // Two cycles in which tx_busy is ignored while the UART reacts.
        if (arm_q) state_d = S_WAIT_TX;
        else       arm_d   = 1'b1;
      end
      S_WAIT_TX: begin
        if (!tx_busy) begin
          gap_d = 16'd0;
          if (GAP_CYCLES == 0) byte_end = 1'b1;
          else                 state_d  = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) byte_end = 1'b1;
        else                   gap_d    = gap_q + 16'd1;
      end
      default: state_d = S_IDLE;
    endcase
    if (byte_end) begin
      if (idx_q < LAST_IDX) begin
        idx_d   = idx_q + 5'd1;
        state_d = S_ISSUE;
      end else begin
        done_c  = 1'b1;
        state_d = S_IDLE;
      end
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= 5'd0;
      gap_q   <= 16'd0;
      arm_q   <= 1'b0;
      snap_q  <= '0;
      txen_q  <= 1'b0;
      txdb_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
      arm_q   <= arm_d;
      snap_q  <= snap_d;
      txen_q  <= txen_d;
      txdb_q  <= txdb_d;
    end
  end

  assign txen       = txen_q;
  assign txdb       = txdb_q;
  assign busy       = (state_q != S_IDLE);
  assign frame_done = done_c & ~rst;
  assign start_drop = start & ~rst & (state_q != S_IDLE);
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_tx_frame_packer.sv
// Bench for tx_frame_packer: four configurations share one clock, one is
// exercised at a time; a negedge monitor scores every txen byte against exp_q.
module tb_tx_frame_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  start_v = 4'b0000;
  logic [31:0] data0 = '0;
  logic [31:0] data1 = '0;
  logic [7:0]  data2 = '0;
  logic [31:0] data3 = '0;
  logic [3:0]  tx_busy_v;

  logic [3:0]  txen_w;
  logic [7:0]  txdb_w [4];
  logic [3:0]  busy_w;
  logic [3:0]  fd_w;
  logic [3:0]  sd_w;
  logic [2:0]  st_w [4];

  logic [1:0]  sel = 2'd0;
  logic        txen_m, busy_m, fd_m, sd_m;
  logic [7:0]  txdb_m;
  logic [2:0]  state_m;

  logic [7:0]  exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          tx_cnt = 0;
  int          fd_cnt = 0;
  int          sd_cnt = 0;
  int          tx_base, fd_base, sd_base;
  int          ucnt [4] = '{0, 0, 0, 0};
  logic [3:0]  uart_en = 4'b0111;

  // clock / reset block
  always #5 clk = ~clk;

  tx_frame_packer #(.NBYTES(4), .HEADER(8'hAA), .CSUM_MODE(0), .GAP_CYCLES(16)) u_xor (
    .clk(clk), .rst(rst), .start(start_v[0]), .data_in(data0), .tx_busy(tx_busy_v[0]),
    .txen(txen_w[0]), .txdb(txdb_w[0]), .busy(busy_w[0]), .frame_done(fd_w[0]),
    .start_drop(sd_w[0]), .state_dbg(st_w[0]));

  tx_frame_packer #(.NBYTES(4), .HEADER(8'hAA), .CSUM_MODE(1), .GAP_CYCLES(16)) u_sum (
    .clk(clk), .rst(rst), .start(start_v[1]), .data_in(data1), .tx_busy(tx_busy_v[1]),
    .txen(txen_w[1]), .txdb(txdb_w[1]), .busy(busy_w[1]), .frame_done(fd_w[1]),
    .start_drop(sd_w[1]), .state_dbg(st_w[1]));

  tx_frame_packer #(.NBYTES(1), .HEADER(8'hAA), .CSUM_MODE(0), .GAP_CYCLES(16)) u_one (
    .clk(clk), .rst(rst), .start(start_v[2]), .data_in(data2), .tx_busy(tx_busy_v[2]),
    .txen(txen_w[2]), .txdb(txdb_w[2]), .busy(busy_w[2]), .frame_done(fd_w[2]),
    .start_drop(sd_w[2]), .state_dbg(st_w[2]));

  tx_frame_packer #(.NBYTES(4), .HEADER(8'hAA), .CSUM_MODE(0), .GAP_CYCLES(0)) u_nogap (
    .clk(clk), .rst(rst), .start(start_v[3]), .data_in(data3), .tx_busy(tx_busy_v[3]),
    .txen(txen_w[3]), .txdb(txdb_w[3]), .busy(busy_w[3]), .frame_done(fd_w[3]),
    .start_drop(sd_w[3]), .state_dbg(st_w[3]));

  // UART model: busy for 10 cycles after each load; instance 3 never busy.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (txen_w[i] && uart_en[i]) ucnt[i] <= 10;
      else if (ucnt[i] != 0)       ucnt[i] <= ucnt[i] - 1;
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) tx_busy_v[i] = (ucnt[i] != 0);
  end

  assign txen_m  = txen_w[sel];
  assign txdb_m  = txdb_w[sel];
  assign busy_m  = busy_w[sel];
  assign fd_m    = fd_w[sel];
  assign sd_m    = sd_w[sel];
  assign state_m = st_w[sel];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // scoreboard: every byte strobed by the active instance is popped from exp_q
  always @(negedge clk) begin
    logic [7:0] e;
    if (txen_m) begin
      tx_cnt++;
      if (exp_q.size() == 0) begin
        check("extra_txen", 32'(txen_m), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("txdb", 32'(txdb_m), 32'(e));
      end
    end
    if (fd_m) fd_cnt++;
    if (sd_m) sd_cnt++;
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic set_base();
    tx_base = tx_cnt;
    fd_base = fd_cnt;
    sd_base = sd_cnt;
  endtask

  task automatic push_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input logic [7:0] b3, input logic [7:0] b4, input logic [7:0] b5);
    exp_q.push_back(b0); exp_q.push_back(b1); exp_q.push_back(b2);
    exp_q.push_back(b3); exp_q.push_back(b4); exp_q.push_back(b5);
  endtask

  task automatic pulse_start(input int idx);
    tick();
    start_v[idx] = 1'b1;
    tick();
    start_v[idx] = 1'b0;
  endtask

  task automatic wait_tx(input int target, input string tag);
    int n = 0;
    while ((tx_cnt - tx_base) < target && n < 4000) begin sample(); n++; end
    if ((tx_cnt - tx_base) < target) check(tag, 32'(tx_cnt - tx_base), 32'(target));
  endtask

  task automatic wait_fd(input int target, input string tag);
    int n = 0;
    while ((fd_cnt - fd_base) < target && n < 4000) begin sample(); n++; end
    if ((fd_cnt - fd_base) < target) check(tag, 32'(fd_cnt - fd_base), 32'(target));
  endtask

  task automatic wait_txen(output int n);
    n = 0;
    do begin sample(); n++; end while (!txen_m && n < 100);
  endtask

  task automatic idle(input int cycles);
    for (int k = 0; k < cycles; k++) sample();
  endtask

  initial begin
    int n;

    // reset: all instances quiet while rst is held
    tick(); tick(); tick();
    sample();
    for (int i = 0; i < 4; i++) begin
      check("rst_txen", 32'(txen_w[i]), 32'd0);
      check("rst_txdb", 32'(txdb_w[i]), 32'd0);
      check("rst_busy", 32'(busy_w[i]), 32'd0);
      check("rst_state", 32'(st_w[i]), 32'd0);
    end
    tick();
    rst = 1'b0;

    // XOR frame, header latency, data change mid-frame, dropped start
    sel = 2'd0;
    set_base();
    data0 = 32'h12345678;
    push_frame(8'hAA, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08);
    pulse_start(0);
    wait_txen(n);
    check("hdr_latency", 32'(n), 32'd2);
    tick();
    data0 = 32'hDEADBEEF;
    wait_tx(4, "wait_byte3");
    tick();
    start_v[0] = 1'b1;
    sample();
    check("start_drop_mid", 32'(sd_m), 32'd1);
    check("busy_mid", 32'(busy_m), 32'd1);
    tick();
    start_v[0] = 1'b0;
    wait_fd(1, "xor_done_timeout");
    check("busy_at_done", 32'(busy_m), 32'd1);
    sample();
    check("busy_after_done", 32'(busy_m), 32'd0);
    idle(40);
    check("xor_bytes", 32'(tx_cnt - tx_base), 32'd6);
    check("xor_exp_empty", 32'(exp_q.size()), 32'd0);
    check("xor_done_cnt", 32'(fd_cnt - fd_base), 32'd1);
    check("xor_drop_cnt", 32'(sd_cnt - sd_base), 32'd1);

    // sum checksum with start held high: two back-to-back frames
    sel = 2'd1;
    set_base();
    data1 = 32'h12345678;
    push_frame(8'hAA, 8'h12, 8'h34, 8'h56, 8'h78, 8'h14);
    push_frame(8'hAA, 8'h12, 8'h34, 8'h56, 8'h78, 8'h14);
    tick();
    start_v[1] = 1'b1;
    wait_fd(1, "sum_done1_timeout");
    check("drop_with_done", 32'(sd_m), 32'd1);
    tick();
    sample();
    check("idle_between", 32'(state_m), 32'd0);
    check("no_drop_in_idle", 32'(sd_m), 32'd0);
    tick();
    start_v[1] = 1'b0;
    wait_fd(2, "sum_done2_timeout");
    idle(40);
    check("sum_bytes", 32'(tx_cnt - tx_base), 32'd12);
    check("sum_exp_empty", 32'(exp_q.size()), 32'd0);
    check("sum_done_cnt", 32'(fd_cnt - fd_base), 32'd2);

    // single payload byte
    sel = 2'd2;
    set_base();
    data2 = 8'hFF;
    exp_q.push_back(8'hAA); exp_q.push_back(8'hFF); exp_q.push_back(8'hFF);
    pulse_start(2);
    wait_fd(1, "one_done_timeout");
    idle(30);
    check("one_bytes", 32'(tx_cnt - tx_base), 32'd3);
    check("one_exp_empty", 32'(exp_q.size()), 32'd0);

    // reset during WAIT_TX of byte 2, start held in the reset cycle
    sel = 2'd0;
    set_base();
    data0 = 32'h12345678;
    exp_q.push_back(8'hAA); exp_q.push_back(8'h12); exp_q.push_back(8'h34);
    pulse_start(0);
    wait_tx(3, "rst_byte2_timeout");
    n = 0;
    while (state_m != 3'd3 && n < 50) begin sample(); n++; end
    check("reach_wait_tx", 32'(state_m), 32'd3);
    tick();
    rst = 1'b1;
    start_v[0] = 1'b1;
    tick();
    rst = 1'b0;
    start_v[0] = 1'b0;
    sample();
    check("abort_state", 32'(state_m), 32'd0);
    check("abort_txen", 32'(txen_m), 32'd0);
    check("abort_txdb", 32'(txdb_m), 32'd0);
    check("abort_busy", 32'(busy_m), 32'd0);
    check("abort_done", 32'(fd_m), 32'd0);
    check("abort_drop", 32'(sd_m), 32'd0);
    idle(60);
    check("abort_bytes", 32'(tx_cnt - tx_base), 32'd3);
    check("abort_exp_empty", 32'(exp_q.size()), 32'd0);
    push_frame(8'hAA, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08);
    pulse_start(0);
    wait_fd(1, "restart_done_timeout");
    idle(40);
    check("restart_bytes", 32'(tx_cnt - tx_base), 32'd9);
    check("restart_exp_empty", 32'(exp_q.size()), 32'd0);
    check("restart_done_cnt", 32'(fd_cnt - fd_base), 32'd1);

    // no gap, UART never busy: strobe every 4 cycles
    sel = 2'd3;
    set_base();
    data3 = 32'h12345678;
    push_frame(8'hAA, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08);
    pulse_start(3);
    wait_txen(n);
    check("nogap_hdr_latency", 32'(n), 32'd2);
    for (int k = 1; k < 6; k++) begin
      wait_txen(n);
      check("nogap_period", 32'(n), 32'd4);
    end
    wait_fd(1, "nogap_done_timeout");
    idle(20);
    check("nogap_bytes", 32'(tx_cnt - tx_base), 32'd6);
    check("nogap_exp_empty", 32'(exp_q.size()), 32'd0);
    check("nogap_done_cnt", 32'(fd_cnt - fd_base), 32'd1);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
